// File: rtl/wheel_speed_meter_if.sv
// Bus bundle between the edge-pulse source / speed consumer and wheel_speed_meter.
// The master drives edge pulses and clear; the slave (the meter) returns the measurements.
interface wheel_speed_meter_if #(
  parameter int CNT_W  = 20,
  parameter int PCNT_W = 16
);
  logic              rising_edge;
  logic              falling_edge;
  logic              clear;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  high_time;
  logic              period_valid;
  logic              stalled;
  logic [PCNT_W-1:0] pulse_count;

  modport master (
    output rising_edge, falling_edge, clear,
    input  period, high_time, period_valid, stalled, pulse_count
  );

  modport slave (
    input  rising_edge, falling_edge, clear,
    output period, high_time, period_valid, stalled, pulse_count
  );
endinterface

// File: rtl/wheel_speed_meter.sv
// Wheel-encoder period/duty meter with edge counting and stall timeout.
// Optional duty measurement (high_time) is enabled by defining WHEEL_SPEED_DUTY_EN.
module wheel_speed_meter #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1000000,
  parameter int PCNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  wheel_speed_meter_if.slave bus
);

`ifdef WHEEL_SPEED_DUTY_EN
  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    HIGH       = 2'd1,
    LOW        = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    RUN        = 2'd1
  } state_e;
`endif

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [PCNT_W-1:0] PCNT_ZERO = {PCNT_W{1'b0}};
  localparam logic [PCNT_W-1:0] PCNT_ONE  = {{(PCNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              stalled_q, stalled_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              timeout_s;
  logic              rise_s;

  assign rise_s    = bus.rising_edge;
  assign timeout_s = (cnt_q == TIMEOUT_C);

`ifdef WHEEL_SPEED_DUTY_EN
  logic [CNT_W-1:0]  hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              fall_s;
  assign fall_s = bus.falling_edge;
`else
  logic              unused_fall_s;
  assign unused_fall_s = bus.falling_edge;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a rising edge always outranks timeout and falling edge
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = WAIT_FIRST;
    end else begin
      case (state_q)
`ifdef WHEEL_SPEED_DUTY_EN
        WAIT_FIRST: if (rise_s) state_d = HIGH; else state_d = WAIT_FIRST;
        HIGH: begin
          if (rise_s)         state_d = HIGH;
          else if (timeout_s) state_d = WAIT_FIRST;
          else if (fall_s)    state_d = LOW;
          else                state_d = HIGH;
        end
        LOW: begin
          if (rise_s)         state_d = HIGH;
          else if (timeout_s) state_d = WAIT_FIRST;
          else                state_d = LOW;
        end
`else
        WAIT_FIRST: if (rise_s) state_d = RUN; else state_d = WAIT_FIRST;
        RUN: begin
          if (rise_s)         state_d = RUN;
          else if (timeout_s) state_d = WAIT_FIRST;
          else                state_d = RUN;
        end
`endif
        default: state_d = WAIT_FIRST;
      endcase
    end
  end

  // Datapath / output next values: arm, publish, timeout, or count
  always_comb begin
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;
    pcnt_d    = pcnt_q;
`ifdef WHEEL_SPEED_DUTY_EN
    hi_lat_d  = hi_lat_q;
    high_d    = high_q;
`endif
    if (bus.clear) begin
      cnt_d     = CNT_ZERO;
      period_d  = CNT_ZERO;
      stalled_d = 1'b1;
      pcnt_d    = PCNT_ZERO;
`ifdef WHEEL_SPEED_DUTY_EN
      high_d    = CNT_ZERO;
`endif
    end else if (state_q == WAIT_FIRST) begin
      if (rise_s) begin
        cnt_d  = CNT_ONE;
        pcnt_d = pcnt_q + PCNT_ONE;
      end else begin
        cnt_d  = CNT_ZERO;
      end
    end else if (rise_s) begin
      cnt_d     = CNT_ONE;
      period_d  = cnt_q;
      valid_d   = 1'b1;
      stalled_d = 1'b0;
      pcnt_d    = pcnt_q + PCNT_ONE;
`ifdef WHEEL_SPEED_DUTY_EN
      // A rising edge seen while still HIGH means the falling edge was missed
      if (state_q == LOW) high_d = hi_lat_q; else high_d = CNT_ZERO;
`endif
    end else if (timeout_s) begin
      cnt_d     = CNT_ZERO;
      stalled_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
`ifdef WHEEL_SPEED_DUTY_EN
      if (state_q == HIGH && fall_s) hi_lat_d = cnt_q; else hi_lat_d = hi_lat_q;
`endif
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= CNT_ZERO;
      period_q  <= CNT_ZERO;
      valid_q   <= 1'b0;
      stalled_q <= 1'b1;
      pcnt_q    <= PCNT_ZERO;
`ifdef WHEEL_SPEED_DUTY_EN
      hi_lat_q  <= CNT_ZERO;
      high_q    <= CNT_ZERO;
`endif
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
      pcnt_q    <= pcnt_d;
`ifdef WHEEL_SPEED_DUTY_EN
      hi_lat_q  <= hi_lat_d;
      high_q    <= high_d;
`endif
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.stalled      = stalled_q;
  assign bus.pulse_count  = pcnt_q;
`ifdef WHEEL_SPEED_DUTY_EN
  assign bus.high_time    = high_q;
`else
  assign bus.high_time    = CNT_ZERO;
`endif

endmodule

// File: tb/tb_wheel_speed_meter.sv
// Directed self-checking bench for wheel_speed_meter (TIMEOUT shortened to 1000).
// Expected high_time follows whether WHEEL_SPEED_DUTY_EN is defined for the build.
module tb_wheel_speed_meter;
  localparam int CNT_W   = 20;
  localparam int TIMEOUT = 1000;
  localparam int PCNT_W  = 16;
`ifdef WHEEL_SPEED_DUTY_EN
  localparam int DUTY = 1;
`else
  localparam int DUTY = 0;
`endif

  logic clock;
  logic reset_n;
  int   check_cnt;
  int   err_cnt;

  wheel_speed_meter_if #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) bus ();

  wheel_speed_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .PCNT_W(PCNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int valid, input int period,
                            input int high, input int stalled, input int pcnt);
    check_value({tag, ".period_valid"}, 32'(bus.period_valid), 32'(valid));
    check_value({tag, ".period"},       32'(bus.period),       32'(period));
    check_value({tag, ".high_time"},    32'(bus.high_time),    32'(high));
    check_value({tag, ".stalled"},      32'(bus.stalled),      32'(stalled));
    check_value({tag, ".pulse_count"},  32'(bus.pulse_count),  32'(pcnt));
  endtask

  // One clock cycle with the given input pulses; outputs are stable #1 after the edge
  task automatic step(input logic r, input logic f, input logic c);
    bus.rising_edge  = r;
    bus.falling_edge = f;
    bus.clear        = c;
    @(posedge clock);
    #1;
    bus.rising_edge  = 1'b0;
    bus.falling_edge = 1'b0;
    bus.clear        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    check_cnt = 0;
    err_cnt   = 0;
    reset_n   = 1'b0;
    bus.rising_edge  = 1'b0;
    bus.falling_edge = 1'b0;
    bus.clear        = 1'b0;

    // Reset held 5 cycles, with an edge pulse that must be ignored
    bus.rising_edge = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    bus.rising_edge = 1'b0;
    expect_out("reset", 0, 0, 0, 1, 0);
    reset_n = 1'b1;

    // Falling in WAIT_FIRST is ignored; rise arms only
    step(1'b0, 1'b1, 1'b0);
    expect_out("wait_fall", 0, 0, 0, 1, 0);
    step(1'b1, 1'b0, 1'b0);
    expect_out("arm", 0, 0, 0, 1, 1);

    // Period 100 with falling edge 30 cycles after the rise
    idle(29);
    step(1'b0, 1'b1, 1'b0);
    idle(69);
    step(1'b1, 1'b0, 1'b0);
    expect_out("p100", 1, 100, 30 * DUTY, 0, 2);
    idle(1);
    check_value("p100.strobe_drop", 32'(bus.period_valid), 32'd0);

    // Missed falling edge: period 50, high_time 0
    idle(48);
    step(1'b1, 1'b0, 1'b0);
    expect_out("p50_nofall", 1, 50, 0, 0, 3);

    // Rise and fall together: falling ignored, so next period still has high_time 0
    idle(19);
    step(1'b1, 1'b1, 1'b0);
    expect_out("p20_both", 1, 20, 0, 0, 4);
    idle(9);
    step(1'b1, 1'b0, 1'b0);
    expect_out("p10_after_both", 1, 10, 0, 0, 5);

    // Clear mid-period together with a rising edge: edge ignored
    idle(29);
    step(1'b1, 1'b0, 1'b1);
    expect_out("clear", 0, 0, 0, 1, 0);
    step(1'b1, 1'b0, 1'b0);
    expect_out("clear_arm", 0, 0, 0, 1, 1);
    idle(9);
    step(1'b1, 1'b0, 1'b0);
    expect_out("p10", 1, 10, 0, 0, 2);

    // Timeout: stalled only after cnt reaches TIMEOUT without a rise
    idle(999);
    check_value("pre_timeout.stalled", 32'(bus.stalled), 32'd0);
    idle(1);
    expect_out("timeout", 0, 10, 0, 1, 2);
    step(1'b1, 1'b0, 1'b0);
    expect_out("timeout_rearm", 0, 10, 0, 1, 3);

    // Publish then rise exactly on cnt == TIMEOUT: rising wins
    idle(9);
    step(1'b1, 1'b0, 1'b0);
    expect_out("p10_b", 1, 10, 0, 0, 4);
    idle(999);
    step(1'b1, 1'b0, 1'b0);
    expect_out("p_timeout_edge", 1, 1000, 0, 0, 5);

    // Asynchronous reset mid-measurement
    idle(20);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0, 1, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    expect_out("reset_arm", 0, 0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
